// File: rtl/iob_native_ram_responder_pkg.sv
// iob_native_ram_responder_pkg: shared types and bus-width helpers for the native iob RAM responder.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package iob_native_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WAIT_CNT_W      = 8;
  localparam int MAX_WAIT_STATES = 255;

  // Request is {valid, addr, wdata, wstrb}; response is {rdata, ready}.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_native_ram_responder_if.sv
// iob_native_ram_responder_if: native iob request/response bus with initiator and responder views.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

interface iob_native_ram_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  localparam int REQ_W  = iob_native_ram_responder_pkg::req_width(ADDR_W, DATA_W);
  localparam int RESP_W = iob_native_ram_responder_pkg::resp_width(DATA_W);

  logic [REQ_W-1:0]  req;
  logic [RESP_W-1:0] resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

`default_nettype wire

// File: rtl/iob_ram_sp_be.sv
// iob_ram_sp_be: single-port synchronous RAM with per-byte write enables and registered read data.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module iob_ram_sp_be #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter     HEXFILE = "none"
) (
  input  wire                  clk,
  input  wire                  en_i,
  input  wire [DATA_W/8-1:0]   we_i,
  input  wire [ADDR_W-1:0]     addr_i,
  input  wire [DATA_W-1:0]     d_i,
  output logic [DATA_W-1:0]    d_o
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  generate
    if (HEXFILE != "none") begin : g_hexfile
      $warning("iob_ram_sp_be: HEXFILE contents are preloaded by the memory-init flow");
    end
  endgenerate

  // The output register only moves on reads, so it holds a read result for as long as needed.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i == '0) begin
        dout_q <= mem_q[addr_i];
      end else begin
        for (int b = 0; b < STRB_W; b++) begin
          if (we_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
          end
        end
      end
    end
  end

  assign d_o = dout_q;

endmodule

`default_nettype wire

// File: rtl/iob_native_ram_responder.sv
// iob_native_ram_responder: native iob responder backed by a byte-enabled RAM with programmable wait states.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module iob_native_ram_responder
  import iob_native_ram_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0,
  parameter     HEXFILE     = "none"
) (
  input  wire clk,
  input  wire rst,
  iob_native_ram_responder_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
      $error("iob_native_ram_responder: WAIT_STATES must be in 0..255");
    end
  endgenerate

  logic                  w_valid;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_accept;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_rdata;
  logic [DATA_W-1:0]     w_ram_dout;
  logic                  w_unused_addr;

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  was_write_q;

  assign {w_valid, w_addr, w_wdata, w_wstrb} = bus.req;
  assign w_unused_addr = ^{w_addr[1:0], w_addr[ADDR_W-1:MEM_ADDR_W+2]};

  // Requests are only sampled outside WAIT; the bus is ignored while a response is pending.
  assign w_accept = w_valid && (state_q != ST_WAIT);

  iob_ram_sp_be #(
    .DATA_W  (DATA_W),
    .ADDR_W  (MEM_ADDR_W),
    .HEXFILE (HEXFILE)
  ) u_ram (
    .clk    (clk),
    .en_i   (w_accept),
    .we_i   (w_wstrb),
    .addr_i (w_addr[MEM_ADDR_W+1:2]),
    .d_i    (w_wdata),
    .d_o    (w_ram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      was_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        was_write_q <= |w_wstrb;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (w_valid) begin
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (state_q == ST_RESP);
    w_rdata = '0;
    if (w_ready && !was_write_q) begin
      w_rdata = w_ram_dout;
    end
  end

  assign bus.resp = {w_rdata, w_ready};

endmodule

`default_nettype wire

// File: tb/tb_iob_native_ram_responder.sv
// tb_iob_native_ram_responder: directed and randomized checks of two responders (0 and 3 wait states).
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_iob_native_ram_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;
  localparam int WS0    = 0;
  localparam int WS1    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [REQ_W-1:0]  req_drv  [2];
  logic [RESP_W-1:0] resp_obs [2];

  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];

  int n_checks = 0;
  int n_errors = 0;

  iob_native_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  iob_native_ram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  assign bus0.req    = req_drv[0];
  assign bus1.req    = req_drv[1];
  assign resp_obs[0] = bus0.resp;
  assign resp_obs[1] = bus1.resp;

  iob_native_ram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(10), .WAIT_STATES(WS0), .HEXFILE("none")
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  iob_native_ram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(10), .WAIT_STATES(WS1), .HEXFILE("none")
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input int k, input string tag);
    check_value({tag, "_ready"}, 32'(resp_obs[k][0]), 32'd0);
    check_value({tag, "_rdata"}, resp_obs[k][RESP_W-1:1], 32'd0);
  endtask

  // Reference memory: word index is addr bits [11:2]; writes merge strobed bytes, responses to writes are 0.
  task automatic start_req(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] exp);
    int idx;
    idx = int'(addr[11:2]);
    req_drv[k] = {1'b1, addr, wdata, wstrb};
    if (wstrb == 4'h0) begin
      exp = mdl[k][idx];
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mdl[k][idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (wstrb == 4'hF) known[k][idx] = 1'b1;
      exp = 32'd0;
    end
  endtask

  // Entered and left at a falling edge; returns in the ready cycle so the next call is back-to-back.
  task automatic do_txn(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit junk);
    logic [31:0] exp;
    int ws;
    ws = ws_of(k);
    start_req(k, addr, wdata, wstrb, exp);
    @(posedge clk);
    for (int c = 1; c <= 1 + ws; c++) begin
      @(negedge clk);
      if (c < 1 + ws) begin
        check_quiet(k, $sformatf("d%0d_wait", k));
        if (junk) begin
          req_drv[k] = {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
                        4'($urandom_range(0, 15))};
        end
      end else begin
        check_value($sformatf("d%0d_ready", k), 32'(resp_obs[k][0]), 32'd1);
        check_value($sformatf("d%0d_rdata@%08h", k, addr), resp_obs[k][RESP_W-1:1], exp);
      end
    end
  endtask

  task automatic idle(input int k, input int n);
    req_drv[k] = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_quiet(k, $sformatf("d%0d_idle", k));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req_drv[0] = '0;
    req_drv[1] = '0;
    #1;
    check_quiet(0, "rst_async_d0");
    check_quiet(1, "rst_async_d1");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] addr;
    logic [3:0]  strb;
    int          idx;

    req_drv[0] = '0;
    req_drv[1] = '0;
    repeat (3) @(negedge clk);
    check_quiet(0, "reset_d0");
    check_quiet(1, "reset_d1");
    rst = 1'b0;
    @(negedge clk);

    // Zero wait states: write then back-to-back read-after-write.
    do_txn(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
    // Partial write keeps unstrobed bytes.
    do_txn(0, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0);
    do_txn(0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b0);
    do_txn(0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
    // Address wrap and ignored low bits.
    do_txn(0, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 1'b0);
    do_txn(0, 32'h0000_1004, 32'h0, 4'h0, 1'b0);
    do_txn(0, 32'h0000_0007, 32'h0, 4'h0, 1'b0);
    idle(0, 2);

    // Three wait states: bus is scrambled during the wait cycles.
    do_txn(1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 1'b0);
    do_txn(1, 32'h0000_0030, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_txn(1, 32'h0000_0030 + 32'(i % 2) * 32'h1000, 32'h0, 4'h0, 1'b1);
    end
    idle(1, 2);

    // Reset during the wait of a write: the write already landed in RAM.
    start_req(1, 32'h0000_0040, 32'h5A5A_1234, 4'hF, exp);
    @(posedge clk);
    @(negedge clk);
    check_quiet(1, "wr_pre_rst");
    pulse_reset();
    idle(1, 6);
    do_txn(1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    idle(1, 1);

    // Reset in cycle 2 of a pending read: no response follows.
    start_req(1, 32'h0000_0040, 32'h0, 4'h0, exp);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    pulse_reset();
    idle(1, 6);

    // Reset while ready is high clears the response at once.
    do_txn(1, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
    pulse_reset();
    idle(1, 3);
    idle(0, 1);

    // Randomized mix of reads, full and partial writes, with and without idle gaps.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 60; n++) begin
        idx  = $urandom_range(0, 31);
        addr = (32'($urandom) & 32'hFFFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
        if (!known[k][idx]) begin
          strb = 4'hF;
        end else if ($urandom_range(0, 1) == 1) begin
          strb = 4'($urandom_range(0, 15));
        end else begin
          strb = 4'h0;
        end
        do_txn(k, addr, 32'($urandom), strb, (k == 1) && ($urandom_range(0, 1) == 1));
        if ($urandom_range(0, 2) == 0) idle(k, $urandom_range(1, 3));
      end
      idle(k, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iob_native_ram_responder.md
Name: iob_native_ram_responder

Overview:
- Responder (slave) end of the native iob request/response bus: accepts `REQ_W`-wide requests `{valid, addr, wdata, wstrb}` and returns `RESP_W`-wide responses `{rdata, ready}`.
- Backs the bus with an internal byte-enabled word RAM and inserts a programmable number of wait states.
- Used as boot/scratch memory on either CPU bus, and as the bench target for initiator wrappers.
- Supports back-to-back transactions: a new request is accepted in the same cycle `ready` is pulsed.

Parameters:
- ADDR_W, 32, byte-address width of the request.
- DATA_W, 32, data width; `wstrb` width is DATA_W/8.
- MEM_ADDR_W, 10, log2 of RAM depth in words.
- WAIT_STATES, 0, extra cycles inserted between acceptance and the `ready` pulse (0..255).
- HEXFILE, "none", optional RAM init file; "none" means contents are uninitialised.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  `REQ_W`  request `{valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}`.
- resp  out  `RESP_W`  response `{rdata[DATA_W-1:0], ready}`.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset values: `ready`=0, `rdata`=0, state=IDLE, wait counter=0. RAM contents are not reset.
- Address mapping:
  - word index = `addr[MEM_ADDR_W+1:2]`.
  - `addr[1:0]` and `addr[ADDR_W-1:MEM_ADDR_W+2]` are ignored, so accesses wrap modulo RAM size.
- Transaction type:
  - write if `wstrb` != 0: only bytes with a set strobe bit are updated.
  - read if `wstrb` == 0.
- Acceptance:
  - A request is accepted in any cycle where state ∈ {IDLE, RESP} and `valid`=1.
  - On the accepting edge, `addr`/`wdata`/`wstrb` are captured, the RAM write is committed or the RAM read is issued, and a "was_write" flag is latched.
- States:
  - IDLE: `ready`=0.
    - `valid` → WAIT_STATES==0 ? RESP : WAIT, with counter loaded to WAIT_STATES-1.
    - otherwise stay in IDLE.
  - WAIT: `ready`=0; the `req` bus is ignored (the initiator holds it).
    - counter==0 → RESP.
    - otherwise decrement the counter.
  - RESP: `ready`=1 for exactly one cycle.
    - If `valid`=1 in this cycle, accept the new request (same transitions as IDLE).
    - Otherwise → IDLE.
- Latency: `ready` is asserted exactly 1+WAIT_STATES cycles after the accepting cycle. Throughput with back-to-back requests is one transaction per 1+WAIT_STATES cycles.
- rdata:
  - Equals the RAM word read at acceptance when `ready`=1 and the transaction was a read.
  - Is 0 when `ready`=0, and 0 on write responses.
  - Read data is held in a register across wait states.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the newly written bytes, because the write was committed at the earlier acceptance edge.
- Partial writes: unstrobed bytes are preserved. A response to a write never reflects RAM contents.
- Reset mid-operation:
  - The pending transaction is dropped and `ready` is not issued.
  - A write already committed on its accepting edge stays in the RAM.
- Request protocol violations (`valid` dropped, or fields changed while in WAIT): ignored; the captured values are used.
- Parameter check: WAIT_STATES > 255 is rejected at elaboration.

Decomposition:
- Shared include `iob_intercon.vh` supplies:
  - `REQ_W`, `RESP_W`;
  - the field-select macros `valid(0)`, `address(0,ADDR_W)`, `wdata(0)`, `wstrb(0)`, `rdata(0)`, `ready(0)`.
- `system.vh` supplies the default `ADDR_W` and `DATA_W`.
- One natural sub-module: `iob_ram_sp_be`, a single-port synchronous RAM with per-byte write enable, synchronous read and optional HEXFILE init.
- The FSM, wait counter and response formatting stay in the top module.

Test Plan:
- WAIT_STATES=0:
  - write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF → `ready` on next cycle, `rdata`=0.
  - Read 0x10 issued in the `ready` cycle → `ready` one cycle later with `rdata`=0xDEADBEEF.
- Partial write:
  - preload 0x11223344 at 0x20; write wdata 0xAABBCCDD, wstrb 0x5.
  - Read 0x20 → 0x11BB33DD.
- WAIT_STATES=3:
  - read accepted at cycle 0 → `ready`=0 in cycles 1–3, `ready`=1 only in cycle 4 with correct data.
  - Changing `req.addr` during cycles 1–3 does not change `rdata`.
- Wrap-around, MEM_ADDR_W=10:
  - write 0xCAFEF00D at 0x00000004, then read 0x00001004 → 0xCAFEF00D.
  - Read 0x00000007 → same word.
- Back-to-back stream:
  - 8 consecutive reads, `valid` held high, WAIT_STATES=1 → exactly 8 `ready` pulses, one every 2 cycles.
  - No pulse is lost or duplicated.
- Reset mid-operation:
  - WAIT_STATES=5; assert `rst` during cycle 2 after a read accept → `ready`/`rdata` go to 0 immediately, and no `ready` follows.
  - Write committed before reset remains readable afterwards.
